latency_stats_collector: RTL

- Consumer side of the inference latency counter. Watches the counter's `latency`/`running` outputs and detects each completed measurement on the running 1->0 edge.
- Captures each completed latency into a small FIFO that host/debug logic drains over a valid/ready port.
- Keeps running min, max, saturating sum and sample count for averaging in software.

---
 rtl/latency_stats_collector_pkg.sv | 24 ++
 rtl/latency_stats_collector_fifo.sv | 49 ++++
 rtl/latency_stats_collector.sv | 79 +++++++
 3 files changed

// File: rtl/latency_stats_collector_pkg.sv
// Shared definitions for the latency counter and its statistics collector:
// default latency width, statistics reset constants and a saturating adder.
package latency_stats_collector_pkg;

  localparam int LAT_WIDTH  = 16;
  localparam int STAT_MAX_W = 64;

  // Wide reset patterns; users truncate them to their own register width.
  localparam logic [STAT_MAX_W-1:0] MIN_INIT = '1;
  localparam logic [STAT_MAX_W-1:0] MAX_INIT = '0;

  // Adds a and b, clamping the result to the largest value of a w-bit register.
  function automatic logic [STAT_MAX_W-1:0] sat_add(input logic [STAT_MAX_W-1:0] a,
                                                    input logic [STAT_MAX_W-1:0] b,
                                                    input int unsigned w);
    logic [STAT_MAX_W:0] s;
    logic [STAT_MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ({{STAT_MAX_W{1'b0}}, 1'b1} << w) - {{STAT_MAX_W{1'b0}}, 1'b1};
    if (s > lim) return lim[STAT_MAX_W-1:0];
    return s[STAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/latency_stats_collector_fifo.sv
// Small synchronous sample FIFO with flush; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module lat_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/latency_stats_collector.sv
// Captures each completed latency measurement (running falling edge) into a
// drainable FIFO and keeps min/max/saturating sum/count statistics.
module latency_stats_collector
  import latency_stats_collector_pkg::*;
#(
  parameter int WIDTH     = LAT_WIDTH,
  parameter int DEPTH     = 4,
  parameter int SUM_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     latency,
  input  logic                 running,
  input  logic                 clear,
  output logic                 sample_valid,
  output logic [WIDTH-1:0]     sample_data,
  input  logic                 sample_ready,
  output logic [WIDTH-1:0]     min_lat,
  output logic [WIDTH-1:0]     max_lat,
  output logic [SUM_WIDTH-1:0] lat_sum,
  output logic [CNT_WIDTH-1:0] lat_count,
  output logic                 overflow
);

  logic run_q;
  logic cap;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  // latency still holds the final count in the first cycle running reads 0
  assign cap          = run_q & ~running;
  assign sample_valid = ~fifo_empty;
  assign pop          = sample_valid & sample_ready & ~clear;

  lat_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (cap & ~clear),
    .pop   (pop),
    .din   (latency),
    .dout  (sample_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= 1'b0;
      min_lat   <= WIDTH'(MIN_INIT);
      max_lat   <= WIDTH'(MAX_INIT);
      lat_sum   <= '0;
      lat_count <= '0;
      overflow  <= 1'b0;
    end else begin
      // run_q tracks through clear so an in-flight measurement still lands
      run_q <= running;
      if (clear) begin
        min_lat   <= WIDTH'(MIN_INIT);
        max_lat   <= WIDTH'(MAX_INIT);
        lat_sum   <= '0;
        lat_count <= '0;
        overflow  <= 1'b0;
      end else if (cap) begin
        if (latency < min_lat) min_lat <= latency;
        if (latency > max_lat) max_lat <= latency;
        lat_sum   <= SUM_WIDTH'(sat_add(STAT_MAX_W'(lat_sum), STAT_MAX_W'(latency), SUM_WIDTH));
        lat_count <= CNT_WIDTH'(sat_add(STAT_MAX_W'(lat_count), STAT_MAX_W'(1), CNT_WIDTH));
        if (fifo_full && !pop) overflow <= 1'b1;
      end
    end
  end

endmodule
